writeback_arbiter: RTL and testbench

//   Shares the reorder buffer's single result-update port (the common data bus) between the

---
 rtl/writeback_arbiter_if.sv | 29 ++
 rtl/writeback_arbiter.sv | 131 +++++++++++++
 tb/tb_writeback_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Result-source and common-data-bus signals between the RS/LSB/ROB side and the writeback arbiter.
// The master drives results and the flush; the slave (the arbiter) drives accepts and the bus.
interface writeback_arbiter_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 clear;
    logic                 rsValid;
    logic [ROB_WIDTH-1:0] rsRobIndex;
    logic [31:0]          rsValue;
    logic                 rsAccept;
    logic                 lsbValid;
    logic [ROB_WIDTH-1:0] lsbRobIndex;
    logic [31:0]          lsbValue;
    logic                 lsbAccept;
    logic                 cdbValid;
    logic [ROB_WIDTH-1:0] cdbRobIndex;
    logic [31:0]          cdbValue;
    logic                 cdbFromLsb;

    modport master (
        output clear, rsValid, rsRobIndex, rsValue, lsbValid, lsbRobIndex, lsbValue,
        input  rsAccept, lsbAccept, cdbValid, cdbRobIndex, cdbValue, cdbFromLsb
    );

    modport slave (
        input  clear, rsValid, rsRobIndex, rsValue, lsbValid, lsbRobIndex, lsbValue,
        output rsAccept, lsbAccept, cdbValid, cdbRobIndex, cdbValue, cdbFromLsb
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Two per-source result FIFOs (0 = reservation station, 1 = load/store buffer) drained
// round-robin, one entry per cycle, onto a registered common data bus.
module writeback_arbiter #(
    parameter int ROB_WIDTH = 4,
    parameter int BUF_WIDTH = 1
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    writeback_arbiter_if.slave   bus
);
    localparam int DEPTH = 1 << BUF_WIDTH;
    localparam logic [BUF_WIDTH:0] FULL = DEPTH[BUF_WIDTH:0];

    logic [1:0]           in_valid;
    logic [ROB_WIDTH-1:0] in_idx   [2];
    logic [31:0]          in_val   [2];
    logic [1:0]           accept;
    logic [1:0]           push;
    logic [1:0]           pop;
    logic [1:0]           not_empty;
    logic [ROB_WIDTH-1:0] head_idx [2];
    logic [31:0]          head_val [2];

    logic                 grant_lsb;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_WIDTH-1:0] cdb_idx_q, cdb_idx_d;
    logic [31:0]          cdb_val_q, cdb_val_d;
    logic                 cdb_from_lsb_q, cdb_from_lsb_d;
    logic                 last_grant_lsb_q, last_grant_lsb_d;

    assign in_valid  = {bus.lsbValid, bus.rsValid};
    assign in_idx[0] = bus.rsRobIndex;
    assign in_idx[1] = bus.lsbRobIndex;
    assign in_val[0] = bus.rsValue;
    assign in_val[1] = bus.lsbValue;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [BUF_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
            logic [BUF_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
            logic [BUF_WIDTH:0]   count_q, count_d;
            logic [ROB_WIDTH-1:0] idx_mem [DEPTH];
            logic [31:0]          val_mem [DEPTH];

            // Accept looks only at the registered count: a pop this cycle frees no slot yet.
            assign accept[gi]    = (count_q != FULL);
            assign not_empty[gi] = (count_q != '0);
            assign push[gi]      = in_valid[gi] & accept[gi];
            assign head_idx[gi]  = idx_mem[rd_ptr_q];
            assign head_val[gi]  = val_mem[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (bus.clear) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
                    if (pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
                    case ({push[gi], pop[gi]})
                        2'b10:   count_d = count_q + 1'b1;
                        2'b01:   count_d = count_q - 1'b1;
                        default: count_d = count_q;
                    endcase
                end
            end

            always_ff @(posedge clockIn) begin
                if (resetIn) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
                if (!resetIn && !bus.clear && push[gi]) begin
                    idx_mem[wr_ptr_q] <= in_idx[gi];
                    val_mem[wr_ptr_q] <= in_val[gi];
                end
            end
        end
    endgenerate

    // On a tie the source that did not win last time is served.
    always_comb begin
        grant_lsb        = (&not_empty) ? ~last_grant_lsb_q : not_empty[1];
        pop              = '0;
        cdb_valid_d      = 1'b0;
        cdb_idx_d        = cdb_idx_q;
        cdb_val_d        = cdb_val_q;
        cdb_from_lsb_d   = cdb_from_lsb_q;
        last_grant_lsb_d = last_grant_lsb_q;
        if (!bus.clear && (|not_empty)) begin
            pop              = grant_lsb ? 2'b10 : 2'b01;
            cdb_valid_d      = 1'b1;
            cdb_idx_d        = grant_lsb ? head_idx[1] : head_idx[0];
            cdb_val_d        = grant_lsb ? head_val[1] : head_val[0];
            cdb_from_lsb_d   = grant_lsb;
            last_grant_lsb_d = grant_lsb;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            cdb_valid_q      <= 1'b0;
            cdb_idx_q        <= '0;
            cdb_val_q        <= '0;
            cdb_from_lsb_q   <= 1'b0;
            last_grant_lsb_q <= 1'b1;
        end else begin
            cdb_valid_q      <= cdb_valid_d;
            cdb_idx_q        <= cdb_idx_d;
            cdb_val_q        <= cdb_val_d;
            cdb_from_lsb_q   <= cdb_from_lsb_d;
            last_grant_lsb_q <= last_grant_lsb_d;
        end
    end

    assign bus.rsAccept    = accept[0];
    assign bus.lsbAccept   = accept[1];
    assign bus.cdbValid    = cdb_valid_q;
    assign bus.cdbRobIndex = cdb_idx_q;
    assign bus.cdbValue    = cdb_val_q;
    assign bus.cdbFromLsb  = cdb_from_lsb_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, latency, round-robin ties, backpressure,
// flush, sustained dual-source traffic and mid-run reset.
module tb_writeback_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    writeback_arbiter_if #(.ROB_WIDTH(4)) bus ();

    writeback_arbiter #(.ROB_WIDTH(4), .BUF_WIDTH(1)) dut (
        .clockIn (clk),
        .resetIn (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_bus(input string tag, input logic v, input logic [3:0] idx,
                           input logic [31:0] val, input logic from_lsb);
        chk({tag, "_valid"}, bus.cdbValid, v);
        chk({tag, "_idx"},   bus.cdbRobIndex, idx);
        chk({tag, "_val"},   bus.cdbValue, val);
        chk({tag, "_src"},   bus.cdbFromLsb, from_lsb);
    endtask

    task automatic drive_rs(input logic v, input logic [3:0] idx, input logic [31:0] val);
        bus.rsValid = v; bus.rsRobIndex = idx; bus.rsValue = val;
    endtask

    task automatic drive_lsb(input logic v, input logic [3:0] idx, input logic [31:0] val);
        bus.lsbValid = v; bus.lsbRobIndex = idx; bus.lsbValue = val;
    endtask

    int   rs_in, lsb_in, rs_out, lsb_out;
    logic exp_src, ra, la, saw_full;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.clear = 1'b0;
        drive_rs(1'b0, 4'h0, 32'h0);
        drive_lsb(1'b0, 4'h0, 32'h0);
        tick();
        tick();
        chk_bus("reset", 1'b0, 4'h0, 32'h0, 1'b0);
        chk("reset_rsAccept", bus.rsAccept, 1'b1);
        chk("reset_lsbAccept", bus.lsbAccept, 1'b1);
        rst = 1'b0;

        // single RS result, two-edge latency
        drive_rs(1'b1, 4'h3, 32'h11);
        tick();
        drive_rs(1'b0, 4'h0, 32'h0);
        chk("t1_not_same_edge", bus.cdbValid, 1'b0);
        tick();
        chk_bus("t1_bcast", 1'b1, 4'h3, 32'h11, 1'b0);
        tick();
        chk_bus("t1_idle", 1'b0, 4'h3, 32'h11, 1'b0);

        // fresh reset, then a tie: RS first, then LSB
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_rs(1'b1, 4'h1, 32'hA);
        drive_lsb(1'b1, 4'h2, 32'hB);
        tick();
        drive_rs(1'b0, 4'h0, 32'h0);
        drive_lsb(1'b0, 4'h0, 32'h0);
        tick();
        chk_bus("t2_first", 1'b1, 4'h1, 32'hA, 1'b0);
        tick();
        chk_bus("t2_second", 1'b1, 4'h2, 32'hB, 1'b1);
        // RS alone, so the following tie goes to LSB
        drive_rs(1'b1, 4'h4, 32'hC);
        tick();
        drive_rs(1'b0, 4'h0, 32'h0);
        tick();
        chk_bus("t2_rs_alone", 1'b1, 4'h4, 32'hC, 1'b0);
        drive_rs(1'b1, 4'h5, 32'hD);
        drive_lsb(1'b1, 4'h6, 32'hE);
        tick();
        drive_rs(1'b0, 4'h0, 32'h0);
        drive_lsb(1'b0, 4'h0, 32'h0);
        tick();
        chk_bus("t2_tie_lsb", 1'b1, 4'h6, 32'hE, 1'b1);
        tick();
        chk_bus("t2_tie_rs", 1'b1, 4'h5, 32'hD, 1'b0);
        tick();
        chk("t2_idle", bus.cdbValid, 1'b0);

        // RS streaming alone: drained as fast as filled, each value once, in order
        for (int k = 0; k < 4; k++) begin
            chk("t3_accept", bus.rsAccept, 1'b1);
            drive_rs(1'b1, 4'(7 + k), 32'h20 + 32'(k));
            tick();
            if (k >= 1) chk_bus("t3_stream", 1'b1, 4'(6 + k), 32'h1F + 32'(k), 1'b0);
        end
        drive_rs(1'b0, 4'h0, 32'h0);
        tick();
        chk_bus("t3_last", 1'b1, 4'hA, 32'h23, 1'b0);
        tick();
        chk("t3_idle", bus.cdbValid, 1'b0);

        // fill, then flush with a push in the clear cycle that must be dropped
        drive_rs(1'b1, 4'h1, 32'h30);
        drive_lsb(1'b1, 4'h3, 32'h40);
        tick();
        chk("t4_e1_valid", bus.cdbValid, 1'b0);
        drive_rs(1'b1, 4'h2, 32'h31);
        drive_lsb(1'b1, 4'h4, 32'h41);
        tick();
        chk_bus("t4_e2", 1'b1, 4'h3, 32'h40, 1'b1);
        chk("t4_rs_full", bus.rsAccept, 1'b0);
        chk("t4_lsb_room", bus.lsbAccept, 1'b1);
        drive_rs(1'b0, 4'h0, 32'h0);
        drive_lsb(1'b1, 4'h5, 32'h42);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        drive_lsb(1'b0, 4'h0, 32'h0);
        chk("t4_clear_valid", bus.cdbValid, 1'b0);
        chk("t4_rsAccept", bus.rsAccept, 1'b1);
        chk("t4_lsbAccept", bus.lsbAccept, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_no_stale", bus.cdbValid, 1'b0);
        end

        // sustained dual-source traffic with hold-and-retry sources
        rs_in = 0; lsb_in = 0; rs_out = 0; lsb_out = 0;
        exp_src = 1'b0; saw_full = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive_rs(1'b1, rs_in[3:0], 32'h100 + 32'(rs_in));
            drive_lsb(1'b1, lsb_in[3:0], 32'h200 + 32'(lsb_in));
            ra = bus.rsAccept;
            la = bus.lsbAccept;
            if (!ra || !la) saw_full = 1'b1;
            tick();
            if (ra) rs_in++;
            if (la) lsb_in++;
            if (c >= 1) chk("t5_sustain", bus.cdbValid, 1'b1);
            if (bus.cdbValid) begin
                chk("t5_alternate", bus.cdbFromLsb, exp_src);
                exp_src = ~exp_src;
                if (bus.cdbFromLsb) begin
                    chk_bus("t5_lsb", 1'b1, lsb_out[3:0], 32'h200 + 32'(lsb_out), 1'b1);
                    lsb_out++;
                end else begin
                    chk_bus("t5_rs", 1'b1, rs_out[3:0], 32'h100 + 32'(rs_out), 1'b0);
                    rs_out++;
                end
            end
        end
        drive_rs(1'b0, 4'h0, 32'h0);
        drive_lsb(1'b0, 4'h0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.cdbValid) begin
                if (bus.cdbFromLsb) begin
                    chk_bus("t5_drain_lsb", 1'b1, lsb_out[3:0], 32'h200 + 32'(lsb_out), 1'b1);
                    lsb_out++;
                end else begin
                    chk_bus("t5_drain_rs", 1'b1, rs_out[3:0], 32'h100 + 32'(rs_out), 1'b0);
                    rs_out++;
                end
            end
        end
        chk("t5_backpressure", saw_full, 1'b1);
        chk("t5_rs_count", rs_out, rs_in);
        chk("t5_lsb_count", lsb_out, lsb_in);
        chk("t5_idle", bus.cdbValid, 1'b0);

        // reset while both FIFOs hold data; lastGrant was RS before the reset
        drive_rs(1'b1, 4'h9, 32'h55);
        tick();
        drive_rs(1'b0, 4'h0, 32'h0);
        tick();
        chk_bus("t6_pre", 1'b1, 4'h9, 32'h55, 1'b0);
        drive_rs(1'b1, 4'hA, 32'h60);
        drive_lsb(1'b1, 4'hB, 32'h70);
        tick();
        drive_rs(1'b0, 4'h0, 32'h0);
        drive_lsb(1'b0, 4'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bus("t6_reset", 1'b0, 4'h0, 32'h0, 1'b0);
        chk("t6_rsAccept", bus.rsAccept, 1'b1);
        chk("t6_lsbAccept", bus.lsbAccept, 1'b1);
        tick();
        chk("t6_no_stale", bus.cdbValid, 1'b0);
        drive_rs(1'b1, 4'h1, 32'h61);
        drive_lsb(1'b1, 4'h2, 32'h71);
        tick();
        drive_rs(1'b0, 4'h0, 32'h0);
        drive_lsb(1'b0, 4'h0, 32'h0);
        tick();
        chk_bus("t6_tie_rs", 1'b1, 4'h1, 32'h61, 1'b0);
        tick();
        chk_bus("t6_tie_lsb", 1'b1, 4'h2, 32'h71, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
